// File: rtl/axis_cpu_loader_pkg.sv
// axis_cpu_loader_pkg
//   Shared definitions for the AXI-Stream CPU loader.
//   Contents: header target codes, loader FSM states, header field
//   positions and a helper that decodes the payload word count.
package axis_cpu_loader_pkg;

  // Header [31:30] target selector.
  typedef enum logic [1:0] {
    LOAD_TGT_INST   = 2'b00,
    LOAD_TGT_IMM    = 2'b01,
    LOAD_TGT_JMP    = 2'b10,
    LOAD_TGT_COMMIT = 2'b11
  } load_tgt_t;

  typedef enum logic [1:0] {
    S_HDR   = 2'd0,
    S_DATA  = 2'd1,
    S_DRAIN = 2'd2
  } load_state_t;

  // Header word layout.
  localparam int HDR_TGT_LSB = 30;
  localparam int HDR_CNT_MSB = 29;
  localparam int HDR_CNT_LSB = 16;

  // Remaining-word counter width: holds 1..16384.
  localparam int REM_WIDTH = 15;

  // Immediates and jump tables are 16 entries deep.
  localparam int TBL_ADDR_WIDTH = 4;

  // Payload word count N = (count-1 field) + 1.
  function automatic logic [REM_WIDTH-1:0] hdr_count(input logic [31:0] hdr);
    return {1'b0, hdr[HDR_CNT_MSB:HDR_CNT_LSB]} + 15'd1;
  endfunction

endpackage

// File: rtl/axis_cpu_loader_if.sv
// axis_cpu_loader_if
//   32-bit AXI-Stream carrying loader headers and payload words.
//   Signals: TDATA (word), TVALID, TREADY, TLAST (end of config packet).
//   Modports: master = stream source (host), slave = loader.
interface axis_cpu_loader_if;
  logic [31:0] TDATA;
  logic        TVALID;
  logic        TREADY;
  logic        TLAST;

  modport master (output TDATA, output TVALID, output TLAST, input TREADY);
  modport slave  (input TDATA, input TVALID, input TLAST, output TREADY);
endinterface

// File: rtl/axis_cpu_loader.sv
// axis_cpu_loader
//   Parses a stream of load segments and drives the CPU programming ports
//   (instruction memory, immediates table, jump-offset table). Holds the
//   CPU in reset from any load header until a valid commit.
// Ports:
//   clk, rst                 clock, async active-high reset
//   cfg (slave)              command/payload stream
//   inst_mem_wr_addr/data/en instruction memory write port
//   imm_wr_addr/data/en      immediates table write port
//   jmp_off_wr_addr/data/en  jump-offset table write port
//   cpu_rst                  reset to CPU controller/datapath
//   busy                     a segment (load or drain) is in progress
//   err                      sticky error, cleared by reset or commit
//
// state   | meaning
// S_HDR   | next accepted word is a header
// S_DATA  | writing payload words to the latched target
// S_DRAIN | discarding words after a malformed commit until TLAST
module axis_cpu_loader
  import axis_cpu_loader_pkg::*;
#(
  parameter int CODE_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  axis_cpu_loader_if.slave           cfg,
  output logic [CODE_ADDR_WIDTH-1:0] inst_mem_wr_addr,
  output logic [7:0]                 inst_mem_wr_data,
  output logic                       inst_mem_wr_en,
  output logic [TBL_ADDR_WIDTH-1:0]  imm_wr_addr,
  output logic [31:0]                imm_wr_data,
  output logic                       imm_wr_en,
  output logic [TBL_ADDR_WIDTH-1:0]  jmp_off_wr_addr,
  output logic [7:0]                 jmp_off_wr_data,
  output logic                       jmp_off_wr_en,
  output logic                       cpu_rst,
  output logic                       busy,
  output logic                       err
);

  load_state_t                state_q, state_d;
  load_tgt_t                  tgt_q, tgt_d;
  logic [CODE_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [REM_WIDTH-1:0]       rem_q, rem_d;
  logic                       cpu_rst_q, cpu_rst_d;
  logic                       err_q, err_d;
  logic                       ready_q;
  logic                       accept;
  logic                       wr_inst, wr_imm, wr_jmp;
  load_tgt_t                  hdr_tgt;

  assign accept     = cfg.TVALID & ready_q;
  assign hdr_tgt    = load_tgt_t'(cfg.TDATA[HDR_TGT_LSB +: 2]);
  assign cfg.TREADY = ready_q;
  assign cpu_rst    = cpu_rst_q;
  assign err        = err_q;
  assign busy       = (state_q != S_HDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_HDR;
      tgt_q     <= LOAD_TGT_INST;
      addr_q    <= '0;
      rem_q     <= '0;
      cpu_rst_q <= 1'b1;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      cpu_rst_q <= cpu_rst_d;
      err_q     <= err_d;
      ready_q   <= 1'b1;  // no backpressure once out of reset
    end
  end

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    cpu_rst_d = cpu_rst_q;
    err_d     = err_q;
    wr_inst   = 1'b0;
    wr_imm    = 1'b0;
    wr_jmp    = 1'b0;

    case (state_q)
      S_HDR: begin
        if (accept) begin
          if (hdr_tgt == LOAD_TGT_COMMIT) begin
            // A commit must have all other header bits clear.
            if (cfg.TDATA[HDR_CNT_MSB:0] == '0) begin
              cpu_rst_d = 1'b0;
              err_d     = 1'b0;
            end else begin
              err_d   = 1'b1;
              state_d = S_DRAIN;
            end
          end else begin
            tgt_d     = hdr_tgt;
            addr_d    = cfg.TDATA[CODE_ADDR_WIDTH-1:0];
            rem_d     = hdr_count(cfg.TDATA);
            cpu_rst_d = 1'b1;
            state_d   = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          case (tgt_q)
            LOAD_TGT_INST: wr_inst = 1'b1;
            LOAD_TGT_IMM:  wr_imm  = 1'b1;
            LOAD_TGT_JMP:  wr_jmp  = 1'b1;
            default:       ;
          endcase
          // Small tables use only the low bits, so they wrap mod 16 for free.
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == 15'd1) begin
            state_d = S_HDR;
          end else if (cfg.TLAST) begin
            err_d   = 1'b1;
            state_d = S_HDR;
          end
        end
      end

      S_DRAIN: begin
        if (accept && cfg.TLAST) begin
          state_d = S_HDR;
        end
      end

      default: state_d = S_HDR;
    endcase
  end

  // Registered write-port bank: address/data hold their last value
  // between writes, strobes are single-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_mem_wr_addr <= '0;
      inst_mem_wr_data <= '0;
      inst_mem_wr_en   <= 1'b0;
      imm_wr_addr      <= '0;
      imm_wr_data      <= '0;
      imm_wr_en        <= 1'b0;
      jmp_off_wr_addr  <= '0;
      jmp_off_wr_data  <= '0;
      jmp_off_wr_en    <= 1'b0;
    end else begin
      inst_mem_wr_en <= wr_inst;
      imm_wr_en      <= wr_imm;
      jmp_off_wr_en  <= wr_jmp;
      if (wr_inst) begin
        inst_mem_wr_addr <= addr_q;
        inst_mem_wr_data <= cfg.TDATA[7:0];
      end
      if (wr_imm) begin
        imm_wr_addr <= addr_q[TBL_ADDR_WIDTH-1:0];
        imm_wr_data <= cfg.TDATA;
      end
      if (wr_jmp) begin
        jmp_off_wr_addr <= addr_q[TBL_ADDR_WIDTH-1:0];
        jmp_off_wr_data <= cfg.TDATA[7:0];
      end
    end
  end

endmodule

// File: tb/tb_axis_cpu_loader.sv
module tb_axis_cpu_loader;
  import axis_cpu_loader_pkg::*;

  localparam int CAW = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_cpu_loader_if cfg ();

  logic [CAW-1:0] inst_mem_wr_addr;
  logic [7:0]     inst_mem_wr_data;
  logic           inst_mem_wr_en;
  logic [3:0]     imm_wr_addr;
  logic [31:0]    imm_wr_data;
  logic           imm_wr_en;
  logic [3:0]     jmp_off_wr_addr;
  logic [7:0]     jmp_off_wr_data;
  logic           jmp_off_wr_en;
  logic           cpu_rst;
  logic           busy;
  logic           err;

  axis_cpu_loader #(.CODE_ADDR_WIDTH(CAW)) dut (
    .clk              (clk),
    .rst              (rst),
    .cfg              (cfg),
    .inst_mem_wr_addr (inst_mem_wr_addr),
    .inst_mem_wr_data (inst_mem_wr_data),
    .inst_mem_wr_en   (inst_mem_wr_en),
    .imm_wr_addr      (imm_wr_addr),
    .imm_wr_data      (imm_wr_data),
    .imm_wr_en        (imm_wr_en),
    .jmp_off_wr_addr  (jmp_off_wr_addr),
    .jmp_off_wr_data  (jmp_off_wr_data),
    .jmp_off_wr_en    (jmp_off_wr_en),
    .cpu_rst          (cpu_rst),
    .busy             (busy),
    .err              (err)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Write records: {target, address, data}
  logic [49:0] obs_q[$];
  logic [49:0] exp_q[$];

  function automatic logic [49:0] rec(input int tgt, input int addr, input logic [31:0] data);
    return {tgt[1:0], addr[15:0], data};
  endfunction

  function automatic logic [31:0] mk_hdr(input int tgt, input int n, input int start);
    logic [13:0] cnt;
    cnt = 14'(n - 1);
    return {tgt[1:0], cnt, start[15:0]};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Observe the write ports once per cycle, between active edges.
  always @(negedge clk) begin
    if (!rst && (inst_mem_wr_en || imm_wr_en || jmp_off_wr_en)) begin
      n_assert++;
      assert ($countones({inst_mem_wr_en, imm_wr_en, jmp_off_wr_en}) == 1)
      else begin
        n_fail++;
        $error("FAIL strobe_onehot observed=%b expected=one strobe",
               {inst_mem_wr_en, imm_wr_en, jmp_off_wr_en});
      end
      if (inst_mem_wr_en) obs_q.push_back(rec(0, int'(inst_mem_wr_addr), 32'(inst_mem_wr_data)));
      if (imm_wr_en)      obs_q.push_back(rec(1, int'(imm_wr_addr), imm_wr_data));
      if (jmp_off_wr_en)  obs_q.push_back(rec(2, int'(jmp_off_wr_addr), 32'(jmp_off_wr_data)));
    end
  end

  // One word per cycle; returns 1 ns after the accepting edge.
  task automatic send(input logic [31:0] w, input logic last);
    cfg.TDATA  = w;
    cfg.TVALID = 1'b1;
    cfg.TLAST  = last;
    @(posedge clk);
    #1;
    cfg.TVALID = 1'b0;
    cfg.TLAST  = 1'b0;
  endtask

  // Reference: the writes a segment must produce, from the table rules.
  task automatic model_seg(input int tgt, input int start, input int nw, input logic [31:0] d[$]);
    int size;
    size = (tgt == 0) ? (1 << CAW) : 16;
    for (int i = 0; i < nw; i++)
      exp_q.push_back(rec(tgt, (start + i) % size, (tgt == 1) ? d[i] : (d[i] & 32'hFF)));
  endtask

  task automatic compare_writes(input string tag);
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_wr%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
    obs_q.delete();
    exp_q.delete();
  endtask

  // Sends a header and payload; early >= 0 puts TLAST on that (non-final) word.
  task automatic load_seg(input int tgt, input int n, input int start, input int early);
    logic [31:0] d[$];
    logic [31:0] w;
    int          nw;
    logic        last;
    send(mk_hdr(tgt, n, start), 1'b0);
    nw = (early >= 0) ? early + 1 : n;
    for (int i = 0; i < nw; i++) begin
      w = $urandom;
      d.push_back(w);
      last = (i == nw - 1) ? ((early >= 0) ? 1'b1 : 1'($urandom_range(0, 1))) : 1'b0;
      send(w, last);
    end
    model_seg(tgt, start, nw, d);
  endtask

  initial begin
    logic [31:0] d[$];
    logic [31:0] w;
    int tgt, n, start, early;

    cfg.TDATA  = '0;
    cfg.TVALID = 1'b0;
    cfg.TLAST  = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ctrl", 64'({cfg.TREADY, cpu_rst, busy, err, inst_mem_wr_en, imm_wr_en, jmp_off_wr_en}),
        64'(7'b0100000));
    chk("rst_inst_port", 64'({inst_mem_wr_addr, inst_mem_wr_data}), 64'(0));
    chk("rst_tbl_ports", 64'({imm_wr_addr, imm_wr_data, jmp_off_wr_addr, jmp_off_wr_data}), 64'(0));
    rst = 1'b0;
    #1;
    chk("tready_before_edge", 64'(cfg.TREADY), 64'(0));
    @(posedge clk);
    #1;
    chk("tready_after_edge", 64'(cfg.TREADY), 64'(1));

    // INST segment at 5..7
    send(32'h0002_0005, 1'b0);
    chk("inst_busy", 64'({busy, cpu_rst}), 64'(2'b11));
    d = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) begin
      send(d[i], 1'b0);
      chk($sformatf("inst_direct%0d", i),
          64'({inst_mem_wr_en, 6'(inst_mem_wr_addr), inst_mem_wr_data}),
          64'({1'b1, 6'(5 + i), d[i][7:0]}));
    end
    chk("inst_done", 64'({busy, cpu_rst, err}), 64'(3'b010));
    model_seg(0, 5, 3, d);
    compare_writes("inst_seg");

    // IMM 16 words from address 15, wrapping
    send(32'h400F_000F, 1'b0);
    d.delete();
    for (int i = 0; i < 16; i++) begin
      w = $urandom;
      d.push_back(w);
      send(w, i == 15);
      if (i == 0)  chk("imm_first_addr", 64'(imm_wr_addr), 64'(15));
      if (i == 1)  chk("imm_wrap_addr", 64'(imm_wr_addr), 64'(0));
      if (i == 14) chk("imm_busy_15", 64'(busy), 64'(1));
    end
    chk("imm_last_addr", 64'(imm_wr_addr), 64'(14));
    chk("imm_busy_16", 64'(busy), 64'(0));
    model_seg(1, 15, 16, d);
    compare_writes("imm_seg");

    // JMP 2 words then commit on the next cycle
    d = '{32'hA5A5_A581, 32'h0000_007E};
    send(mk_hdr(2, 2, 3), 1'b0);
    send(d[0], 1'b0);
    send(d[1], 1'b1);
    chk("jmp_last_pulse", 64'({jmp_off_wr_en, cpu_rst}), 64'(2'b11));
    send(32'hC000_0000, 1'b1);
    chk("jmp_commit", 64'({jmp_off_wr_en, cpu_rst, err}), 64'(3'b000));
    model_seg(2, 3, 2, d);
    compare_writes("jmp_seg");

    // INST count 4, TLAST on 2nd word
    load_seg(0, 4, 16'h0100, 1);
    chk("early_last_err", 64'({err, busy, cpu_rst}), 64'(3'b101));
    compare_writes("early_last");
    send(32'hC000_0000, 1'b0);
    chk("commit_clears_err", 64'({err, cpu_rst}), 64'(2'b00));

    // Malformed commit, drain until TLAST
    send(32'hC000_0001, 1'b0);
    chk("bad_commit", 64'({err, busy, cpu_rst}), 64'(3'b110));
    send(32'h0002_0005, 1'b0);
    send(32'h1234_5678, 1'b0);
    chk("drain_busy", 64'(busy), 64'(1));
    send(32'h4000_0000, 1'b1);
    chk("drain_done", 64'({busy, err}), 64'(2'b01));
    compare_writes("drain");
    send(32'hC000_0000, 1'b0);
    chk("drain_commit", 64'({err, cpu_rst}), 64'(2'b00));

    // Randomized segments against the reference
    for (int k = 0; k < 10; k++) begin
      tgt   = int'($urandom_range(0, 2));
      n     = int'($urandom_range(1, 20));
      start = int'($urandom_range(0, 16'hFFFF));
      early = (n > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 2)) : -1;
      load_seg(tgt, n, start, early);
      chk($sformatf("rnd%0d_status", k), 64'({err, busy, cpu_rst}),
          64'({(early >= 0), 1'b0, 1'b1}));
      compare_writes($sformatf("rnd%0d", k));
      send(32'hC000_0000, 1'b0);
      chk($sformatf("rnd%0d_commit", k), 64'({err, cpu_rst}), 64'(2'b00));
    end

    // Reset in the middle of a segment
    send(mk_hdr(0, 4, 9), 1'b0);
    send(32'h0000_00C3, 1'b0);
    chk("mid_pre_rst", 64'({inst_mem_wr_en, busy}), 64'(2'b11));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_ctrl", 64'({cfg.TREADY, cpu_rst, busy, err, inst_mem_wr_en, imm_wr_en, jmp_off_wr_en}),
        64'(7'b0100000));
    chk("mid_rst_inst_port", 64'({inst_mem_wr_addr, inst_mem_wr_data}), 64'(0));
    obs_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_tready_before", 64'(cfg.TREADY), 64'(0));
    @(posedge clk);
    #1;
    chk("mid_tready_after", 64'(cfg.TREADY), 64'(1));
    send(32'hC000_0000, 1'b0);
    chk("mid_hdr_decode", 64'({cpu_rst, busy, err}), 64'(3'b000));
    compare_writes("mid_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
